// File: rtl/wb_initiator_pkg.sv
// Shared definitions for the Wishbone initiator: FSM state and response
// status encodings, plus the timeout counter width helper.
package wb_initiator_pkg;

  // Initiator FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Response status reported on rsp_status.
  typedef enum logic [1:0] {
    STATUS_OK      = 2'd0,
    STATUS_ERR     = 2'd1,
    STATUS_TIMEOUT = 2'd2
  } status_t;

  // Width of a counter that must reach timeout without wrapping.
  // A disabled timeout (0) still gets a 1-bit counter so the vector is legal.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_initiator.sv
// Single-outstanding classic Wishbone initiator. A command is taken in IDLE,
// run as one bus cycle in BUS, and reported back through a held response in
// RESP. A bus cycle ends on ack, err, or the optional timeout.
//
// Handshakes: a transfer on cmd_* or rsp_* happens on a rising edge where
// valid and ready are both high; the producer holds valid and its payload
// stable until that edge, and ready never depends on valid.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_status,
  // Wishbone initiator port
  output logic                  m_cyc,
  output logic                  m_stb,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_data_write,
  input  logic                  m_ack,
  input  logic                  m_err,
  input  logic [DATA_WIDTH-1:0] m_data_read,
  // debug view of the FSM
  output state_t                o_dbg_state
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  // Counter value seen on the TIMEOUT-th BUS edge (counter starts at 0).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                r_state;
  logic                  r_cyc;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  status_t               r_status;
  logic [CNT_W-1:0]      r_cnt;

  logic w_done;
  logic w_timeout;

  // Bus cycle completion terms, only meaningful while in BUS.
  assign w_done    = m_ack | m_err;
  assign w_timeout = (TIMEOUT > 0) && (r_cnt == CNT_LAST);

  // FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_status    <= STATUS_OK;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_we    <= cmd_we;
            r_addr  <= cmd_addr;
            r_wdata <= cmd_data;
            r_cyc   <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (w_done) begin
            // err wins over ack when both are present
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
            if (m_err) begin
              r_status   <= STATUS_ERR;
              r_rsp_data <= '0;
            end else begin
              r_status   <= STATUS_OK;
              r_rsp_data <= r_we ? '0 : m_data_read;
            end
          end else if (w_timeout) begin
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_status    <= STATUS_TIMEOUT;
            r_rsp_data  <= '0;
            r_state     <= ST_RESP;
          end else if (TIMEOUT > 0) begin
            // never reaches CNT_LAST+1, so it cannot wrap
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = (r_state == ST_IDLE);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_status   = r_status;
  assign m_cyc        = r_cyc;
  assign m_stb        = r_cyc;
  assign m_we         = r_we;
  assign m_addr       = r_addr;
  assign m_data_write = r_wdata;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_wb_initiator.sv
// Testbench for wb_initiator (TIMEOUT=4 so the timeout path is reachable).
module tb_wb_initiator;
  import wb_initiator_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int W  = 18;  // {status, data}

  // clock / reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_status;
  logic          m_cyc, m_stb, m_we, m_ack, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data_write, m_data_read;
  state_t        dbg_state;

  wb_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr),
    .m_data_write(m_data_write), .m_ack(m_ack), .m_err(m_err),
    .m_data_read(m_data_read), .o_dbg_state(dbg_state)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- driver tasks ----------------
  // Called at a negedge with the DUT in IDLE; command is taken on the next edge.
  task automatic issue_cmd(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom_range(0, 1));
    cmd_addr  = 16'($urandom);
    cmd_data  = 16'($urandom);
  endtask

  // Responder: counts BUS cycles (m_cyc sampled at negedge) and raises the
  // requested ack/err during cycle ack_at (0 = stay silent).
  task automatic respond(input int ack_at, input logic use_ack, input logic use_err,
                         input logic [DW-1:0] rdata, output int cyc_cnt,
                         output logic [32:0] first_ctl, output bit ctl_stable);
    cyc_cnt    = 0;
    ctl_stable = 1'b1;
    first_ctl  = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!m_cyc) break;
      cyc_cnt++;
      if (cyc_cnt == 1) first_ctl = {m_we, m_addr, m_data_write};
      else if ({m_we, m_addr, m_data_write} !== first_ctl) ctl_stable = 1'b0;
      if (cyc_cnt == ack_at) begin
        m_ack = use_ack; m_err = use_err; m_data_read = rdata;
      end else begin
        m_ack = 1'b0; m_err = 1'b0; m_data_read = 16'($urandom);
      end
    end
    m_ack = 1'b0;
    m_err = 1'b0;
  endtask

  // Waits (bounded) for a response at negedges; consumes it if rsp_ready is high.
  task automatic wait_rsp(output logic [1:0] st, output logic [DW-1:0] d, output bit got);
    got = 1'b0; st = '0; d = '0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        st = rsp_status; d = rsp_data; got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got && rsp_ready) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b1; m_ack = 0; m_err = 0; m_data_read = '0;
    #1;
    n_assert++;
    if ({m_cyc, m_stb, rsp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctl: got %b want 000", {m_cyc, m_stb, rsp_valid});
    end
    n_assert++;
    if ({rsp_status, rsp_data} !== 18'd0) begin
      n_fail++; $display("FAIL reset_rsp: got %h want 0", {rsp_status, rsp_data});
    end
    n_assert++;
    if ({m_we, m_addr, m_data_write} !== 33'd0) begin
      n_fail++; $display("FAIL reset_bus: got %h want 0", {m_we, m_addr, m_data_write});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_assert++;
    if (cmd_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_idle: got ready=%b state=%0d want 1/0", cmd_ready, dbg_state);
    end
  endtask

  task automatic test_idle_ack_ignored;
    m_ack = 1'b1; m_err = 1'b1;
    repeat (2) @(negedge clk);
    m_ack = 1'b0; m_err = 1'b0;
    n_assert++;
    if (rsp_valid !== 1'b0 || dbg_state !== ST_IDLE || m_cyc !== 1'b0) begin
      n_fail++; $display("FAIL idle_ack: got valid=%b state=%0d cyc=%b want 0/0/0", rsp_valid, dbg_state, m_cyc);
    end
  endtask

  task automatic test_read_ok;
    int cyc; logic [32:0] ctl; bit stable; logic [1:0] st; logic [DW-1:0] d; bit got;
    exp_q.push_back({STATUS_OK, 16'hBEEF});
    issue_cmd(1'b0, 16'h0012, 16'($urandom));
    respond(3, 1'b1, 1'b0, 16'hBEEF, cyc, ctl, stable);
    n_assert++;
    if (cyc != 3) begin n_fail++; $display("FAIL read_cyc_len: got %0d want 3", cyc); end
    n_assert++;
    if (ctl[32:16] !== {1'b0, 16'h0012} || !stable) begin
      n_fail++; $display("FAIL read_ctl: got we/addr=%h stable=%0d want 0012/1", ctl[32:16], stable);
    end
    wait_rsp(st, d, got);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_assert++;
    if (!got || {st, d} !== exp_v) begin
      n_fail++; $display("FAIL read_rsp: got %h (seen=%0d) want %h", {st, d}, got, exp_v);
    end
  endtask

  task automatic test_write_err;
    int cyc; logic [32:0] ctl; bit stable; logic [1:0] st; logic [DW-1:0] d; bit got;
    exp_q.push_back({STATUS_ERR, 16'h0000});
    issue_cmd(1'b1, 16'h0004, 16'h1234);
    respond(1, 1'b1, 1'b1, 16'hFFFF, cyc, ctl, stable);
    n_assert++;
    if (cyc != 1) begin n_fail++; $display("FAIL write_cyc_len: got %0d want 1", cyc); end
    n_assert++;
    if (ctl !== {1'b1, 16'h0004, 16'h1234} || m_data_write !== 16'h1234) begin
      n_fail++; $display("FAIL write_ctl: got %h now=%h want 1_0004_1234", ctl, m_data_write);
    end
    wait_rsp(st, d, got);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_assert++;
    if (!got || {st, d} !== exp_v) begin
      n_fail++; $display("FAIL write_err_rsp: got %h (seen=%0d) want %h", {st, d}, got, exp_v);
    end
  endtask

  task automatic test_timeout;
    int cyc; logic [32:0] ctl; bit stable; logic [1:0] st; logic [DW-1:0] d; bit got;
    // silent responder
    exp_q.push_back({STATUS_TIMEOUT, 16'h0000});
    issue_cmd(1'b0, 16'h0100, 16'h0);
    respond(0, 1'b0, 1'b0, 16'h0, cyc, ctl, stable);
    n_assert++;
    if (cyc != 4) begin n_fail++; $display("FAIL timeout_cyc_len: got %0d want 4", cyc); end
    wait_rsp(st, d, got);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_assert++;
    if (!got || {st, d} !== exp_v) begin
      n_fail++; $display("FAIL timeout_rsp: got %h (seen=%0d) want %h", {st, d}, got, exp_v);
    end
    // ack on the timeout edge wins
    exp_q.push_back({STATUS_OK, 16'h5A5A});
    issue_cmd(1'b0, 16'h0200, 16'h0);
    respond(4, 1'b1, 1'b0, 16'h5A5A, cyc, ctl, stable);
    n_assert++;
    if (cyc != 4) begin n_fail++; $display("FAIL late_ack_cyc_len: got %0d want 4", cyc); end
    wait_rsp(st, d, got);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_assert++;
    if (!got || {st, d} !== exp_v) begin
      n_fail++; $display("FAIL late_ack_rsp: got %h (seen=%0d) want %h", {st, d}, got, exp_v);
    end
  endtask

  task automatic test_backpressure;
    int cyc; logic [32:0] ctl; bit stable; logic [1:0] st; logic [DW-1:0] d; bit got;
    rsp_ready = 1'b0;
    exp_q.push_back({STATUS_OK, 16'hC0DE});
    issue_cmd(1'b0, 16'h0033, 16'h0);
    respond(1, 1'b1, 1'b0, 16'hC0DE, cyc, ctl, stable);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'h0077; cmd_data = 16'h7777;
    for (int i = 0; i < 10; i++) begin
      n_assert++;
      if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, STATUS_OK, 16'hC0DE} ||
          cmd_ready !== 1'b0 || m_cyc !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got v=%b st=%0d d=%h rdy=%b cyc=%b want 1/0/c0de/0/0",
                 i, rsp_valid, rsp_status, rsp_data, cmd_ready, m_cyc);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_rsp(st, d, got);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_assert++;
    if (!got || {st, d} !== exp_v) begin
      n_fail++; $display("FAIL backpressure_rsp: got %h (seen=%0d) want %h", {st, d}, got, exp_v);
    end
  endtask

  task automatic test_reset_mid_bus;
    int cyc; logic [32:0] ctl; bit stable; logic [1:0] st; logic [DW-1:0] d; bit got;
    bit saw_valid;
    issue_cmd(1'b0, 16'h0044, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    n_assert++;
    if ({m_cyc, m_stb} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mid_bus_cyc: got %b want 00", {m_cyc, m_stb});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_assert++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) saw_valid = 1'b1;
    end
    n_assert++;
    if (saw_valid) begin n_fail++; $display("FAIL reset_no_rsp: got rsp_valid=1 want 0"); end
    exp_q.push_back({STATUS_OK, 16'h600D});
    issue_cmd(1'b0, 16'h0045, 16'h0);
    respond(2, 1'b1, 1'b0, 16'h600D, cyc, ctl, stable);
    wait_rsp(st, d, got);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_assert++;
    if (!got || {st, d} !== exp_v || cyc != 2) begin
      n_fail++; $display("FAIL post_reset_rsp: got %h cyc=%0d (seen=%0d) want %h cyc=2", {st, d}, cyc, got, exp_v);
    end
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] addrs[8];
    int issued, got, last_cyc, cyc;
    bit pend;
    issued = 0; got = 0; last_cyc = 0; cyc = 0; pend = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      addrs[k] = 16'($urandom);
      exp_q.push_back({STATUS_OK, addrs[k] ^ 16'hA5A5});
    end
    while (got < 8 && cyc < 100) begin
      if (pend) issued++;
      m_ack       = m_cyc;
      m_data_read = m_addr ^ 16'hA5A5;
      if (rsp_valid) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_assert++;
        if ({rsp_status, rsp_data} !== exp_v) begin
          n_fail++; $display("FAIL b2b_rsp[%0d]: got %h want %h", got, {rsp_status, rsp_data}, exp_v);
        end
        if (got > 0) begin
          n_assert++;
          if (cyc - last_cyc != 3) begin
            n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want 3", got, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        got++;
      end
      cmd_valid = (issued < 8);
      if (issued < 8) begin
        cmd_we = 1'b0; cmd_addr = addrs[issued]; cmd_data = 16'($urandom);
      end
      pend = cmd_valid && cmd_ready;
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    m_ack = 1'b0;
    n_assert++;
    if (got != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", got); end
  endtask

  initial begin
    test_reset;
    test_idle_ack_ignored;
    test_read_ok;
    test_write_err;
    test_timeout;
    test_backpressure;
    test_reset_mid_bus;
    test_back_to_back;
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
